// File: rtl/fme_pkg.sv
// fme_pkg: constants shared by the fractional motion estimation datapath
// (half-pel six-tap filter and the quarter-pel averaging stage).
//   PIX_W      pixel width in bits
//   ACC_W      signed accumulator width for the six-tap sum
//   TAP_*      filter taps (1, -5, 20, 20, -5, 1)
//   RND/SHIFT  rounding offset and normalising shift of the filter gain (32)
//   PIX_MAX    largest representable pixel value
package fme_pkg;

   localparam int PIX_W     = 8;
   localparam int ACC_W     = 15;

   localparam int TAP_OUTER = 1;
   localparam int TAP_MID   = -5;
   localparam int TAP_CTR   = 20;

   localparam int RND       = 16;
   localparam int SHIFT     = 5;
   localparam int PIX_MAX   = 255;

endpackage : fme_pkg

// File: rtl/clip_u8.sv
// clip_u8: round, normalise and saturate a signed filter sum to a pixel.
//   sum_i  in  ACC_W  signed filter sum
//   pix_o  out PIX_W  clip((sum_i + RND) >>> SHIFT, 0, PIX_MAX), combinational
// Shared between the half-pel filter and the quarter-pel averaging stage.
module clip_u8
   import fme_pkg::*;
#(
   parameter int PIX_W = fme_pkg::PIX_W,
   parameter int ACC_W = fme_pkg::ACC_W
) (
   input  logic signed [ACC_W-1:0] sum_i,
   output logic        [PIX_W-1:0] pix_o
);

   localparam logic signed [ACC_W-1:0] RND_S   = ACC_W'(RND);
   localparam logic signed [ACC_W-1:0] MAX_S   = ACC_W'(PIX_MAX);
   localparam logic signed [ACC_W-1:0] ZERO_S  = {ACC_W{1'b0}};
   localparam logic        [PIX_W-1:0] MAX_PIX = PIX_W'(PIX_MAX);

   logic signed [ACC_W-1:0] rnd_s;
   logic signed [ACC_W-1:0] shr_s;

   // Round to nearest (ties upward) then saturate into the pixel range.
   // The headroom in ACC_W guarantees sum_i + RND cannot wrap.
   always_comb begin
      rnd_s = sum_i + RND_S;
      shr_s = rnd_s >>> SHIFT;
      if (shr_s < ZERO_S) begin
         pix_o = {PIX_W{1'b0}};
      end else if (shr_s > MAX_S) begin
         pix_o = MAX_PIX;
      end else begin
         pix_o = shr_s[PIX_W-1:0];
      end
   end

endmodule : clip_u8

// File: rtl/six_tap_filter.sv
// six_tap_filter: H.264 luma half-pel interpolator.
//   clk    in   1      rising-edge clock
//   rst    in   1      asynchronous, active-low reset (clears half)
//   a..f   in   PIX_W  six consecutive pixels, positions -2 .. +3 (unsigned)
//   half   out  PIX_W  clip((a - 5b + 20c + 20d - 5e + f + 16) >>> 5), registered
// One window in and one result out per clock; latency is one clock.
module six_tap_filter
   import fme_pkg::*;
#(
   parameter int PIX_W = fme_pkg::PIX_W,
   parameter int ACC_W = fme_pkg::ACC_W
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [PIX_W-1:0] a,
   input  logic [PIX_W-1:0] b,
   input  logic [PIX_W-1:0] c,
   input  logic [PIX_W-1:0] d,
   input  logic [PIX_W-1:0] e,
   input  logic [PIX_W-1:0] f,
   output logic [PIX_W-1:0] half
);

   localparam int EXT_W = ACC_W - PIX_W;

   logic signed [ACC_W-1:0] a_s, b_s, c_s, d_s, e_s, f_s;
   logic signed [ACC_W-1:0] outer_s;
   logic signed [ACC_W-1:0] mid_s;
   logic signed [ACC_W-1:0] ctr_s;
   logic signed [ACC_W-1:0] sum_s;
   logic        [PIX_W-1:0] clip_s;
   logic        [PIX_W-1:0] half_d;
   logic        [PIX_W-1:0] half_q;

   // Adder tree: taps of 5 and 20 are built from shifts; symmetric pairs are
   // summed first so each product is formed once per pair.
   always_comb begin
      a_s     = $signed({{EXT_W{1'b0}}, a});
      b_s     = $signed({{EXT_W{1'b0}}, b});
      c_s     = $signed({{EXT_W{1'b0}}, c});
      d_s     = $signed({{EXT_W{1'b0}}, d});
      e_s     = $signed({{EXT_W{1'b0}}, e});
      f_s     = $signed({{EXT_W{1'b0}}, f});
      outer_s = a_s + f_s;
      mid_s   = b_s + e_s;
      ctr_s   = c_s + d_s;
      sum_s   = outer_s - ((mid_s <<< 2) + mid_s) + ((ctr_s <<< 4) + (ctr_s <<< 2));
   end

   clip_u8 #(
      .PIX_W (PIX_W),
      .ACC_W (ACC_W)
   ) u_clip (
      .sum_i (sum_s),
      .pix_o (clip_s)
   );

   // Next output value: the clipped result for the window presented this cycle.
   always_comb begin
      half_d = clip_s;
   end

   // Output register with asynchronous clear.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         half_q <= {PIX_W{1'b0}};
      end else begin
         half_q <= half_d;
      end
   end

   assign half = half_q;

endmodule : six_tap_filter

// File: tb/tb_six_tap_filter.sv
// tb_six_tap_filter: self-checking bench for six_tap_filter.
// Inputs change on the falling edge; outputs are sampled 1 ns after the
// rising edge. Expected values come from an integer reference model.
module tb_six_tap_filter;

   logic       clk;
   logic       rst;
   logic [7:0] a, b, c, d, e, f;
   logic [7:0] half;

   int errors;
   int checks;

   six_tap_filter dut (
      .clk  (clk),
      .rst  (rst),
      .a    (a),
      .b    (b),
      .c    (c),
      .d    (d),
      .e    (e),
      .f    (f),
      .half (half)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: plain integer arithmetic with floor division for the rounding.
   function automatic int ref_half(input int pa, input int pb, input int pc,
                                   input int pd, input int pe, input int pf);
      int s;
      int t;
      int r;
      s = pa - 5 * pb + 20 * pc + 20 * pd - 5 * pe + pf;
      t = s + 16;
      if (t >= 0) r = t / 32;
      else        r = -((-t + 31) / 32);
      if (r < 0)        return 0;
      else if (r > 255) return 255;
      else              return r;
   endfunction

   task automatic drive(input int pa, input int pb, input int pc,
                        input int pd, input int pe, input int pf);
      a = 8'(pa); b = 8'(pb); c = 8'(pc);
      d = 8'(pd); e = 8'(pe); f = 8'(pf);
   endtask

   task automatic test_reset;
      rst = 1'b0;
      drive(100, 100, 100, 100, 100, 100);
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (half !== 8'd0) begin
         errors++;
         $display("FAIL reset: half=%0d expected 0", half);
      end
      @(negedge clk);
      rst = 1'b1;
   endtask

   task automatic test_directed;
      int win [8][6];
      int exp_v [8];
      string nm [8];
      win[0] = '{100, 100, 100, 100, 100, 100}; exp_v[0] = 100; nm[0] = "flat";
      win[1] = '{10, 20, 30, 40, 50, 60};       exp_v[1] = 35;  nm[1] = "ramp";
      win[2] = '{0, 0, 255, 255, 0, 0};         exp_v[2] = 255; nm[2] = "sat_high";
      win[3] = '{0, 255, 0, 0, 255, 0};         exp_v[3] = 0;   nm[3] = "sat_low";
      win[4] = '{16, 0, 0, 0, 0, 0};            exp_v[4] = 1;   nm[4] = "round_a16";
      win[5] = '{15, 0, 0, 0, 0, 0};            exp_v[5] = 0;   nm[5] = "round_a15";
      win[6] = '{0, 0, 1, 0, 0, 0};             exp_v[6] = 1;   nm[6] = "round_c1";
      win[7] = '{255, 0, 255, 255, 0, 255};     exp_v[7] = 255; nm[7] = "s_max";
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         drive(win[i][0], win[i][1], win[i][2], win[i][3], win[i][4], win[i][5]);
         @(posedge clk);
         #1;
         checks++;
         if (half !== 8'(exp_v[i])) begin
            errors++;
            $display("FAIL %s: half=%0d expected %0d", nm[i], half, exp_v[i]);
         end
      end
      // Held inputs keep the output steady over several edges.
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (half !== 8'd255) begin
         errors++;
         $display("FAIL hold: half=%0d expected 255", half);
      end
   endtask

   task automatic test_back_to_back;
      int w [6];
      int exp_q [$];
      int expv;
      for (int n = 0; n < 1000; n++) begin
         @(negedge clk);
         for (int k = 0; k < 6; k++) w[k] = int'($urandom_range(0, 255));
         // Bias some windows toward the saturation corners.
         if (n % 10 == 3) begin w[1] = 255; w[4] = 255; w[2] = 0; w[3] = 0; end
         if (n % 10 == 7) begin w[2] = 255; w[3] = 255; w[1] = 0; w[4] = 0; end
         drive(w[0], w[1], w[2], w[3], w[4], w[5]);
         exp_q.push_back(ref_half(w[0], w[1], w[2], w[3], w[4], w[5]));
         @(posedge clk);
         #1;
         expv = exp_q.pop_front();
         checks++;
         if (half !== 8'(expv)) begin
            errors++;
            $display("FAIL b2b[%0d]: half=%0d expected %0d (a..f=%0d,%0d,%0d,%0d,%0d,%0d)",
                     n, half, expv, w[0], w[1], w[2], w[3], w[4], w[5]);
         end
      end
   endtask

   task automatic test_reset_midstream;
      @(negedge clk);
      drive(200, 200, 200, 200, 200, 200);
      @(posedge clk);
      #1;
      checks++;
      if (half !== 8'd200) begin
         errors++;
         $display("FAIL mid_pre: half=%0d expected 200", half);
      end
      #2;
      rst = 1'b0;
      #1;
      checks++;
      if (half !== 8'd0) begin
         errors++;
         $display("FAIL mid_async: half=%0d expected 0", half);
      end
      @(posedge clk);
      #1;
      checks++;
      if (half !== 8'd0) begin
         errors++;
         $display("FAIL mid_held: half=%0d expected 0", half);
      end
      @(negedge clk);
      rst = 1'b1;
      #1;
      checks++;
      if (half !== 8'd0) begin
         errors++;
         $display("FAIL mid_release: half=%0d expected 0", half);
      end
      @(posedge clk);
      #1;
      checks++;
      if (half !== 8'd200) begin
         errors++;
         $display("FAIL mid_restore: half=%0d expected 200", half);
      end
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst = 1'b0;
      drive(0, 0, 0, 0, 0, 0);
      test_reset();
      test_directed();
      test_back_to_back();
      test_reset_midstream();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule : tb_six_tap_filter
